dadda_mac_pipe: RTL and testbench

- Parametrised, pipelined multiply-accumulate unit. Successor to the fixed 8x8 combinational Dadda multiplier.
- Multiplies DW-bit operand pairs through a registered Dadda reduction tree and accumulates TAPS products per group.
- Emits one result per group over a valid/ready handshake.
- Sits between the 3x3 window generator (pixel x weight stream, 9 taps per output pixel) and the output pixel stage of the Gaussian FIR filter.

---
 rtl/dadda_mac_pipe.sv | 173 +++++++++++++++++
 tb/tb_dadda_mac_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mac_pipe.sv
// dadda_mac_pipe: pipelined Baugh-Wooley / carry-save multiply-accumulate, one result per TAPS-tap group.
// Optional macro GAUSS_ROUND_EN: round-half-up right shift of the group result by SHIFT.
`default_nettype none

module dadda_mac_pipe #(
  parameter int DW    = 8,
  parameter int TAPS  = 9,
  parameter int PIPE  = 2,
  parameter int SHIFT = 4,
  localparam int ACC_W = 2*DW + $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data
);

  localparam int PW  = 2*DW;
  localparam int NR  = DW + 1;
  localparam int NST = PIPE + 1;
  localparam int NSL = (PIPE > 1) ? PIPE - 1 : 1;
  localparam int CW  = (TAPS > 1) ? $clog2(TAPS) : 1;

  // Row j < DW holds a*b[j]; row DW holds the Baugh-Wooley correction constants.
  function automatic logic [PW-1:0] bw_row(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic sgn, input int j);
    logic [PW-1:0] row;
    logic          pp;
    row = '0;
    if (j < DW) begin
      for (int i = 0; i < DW; i++) begin
        pp = a[i] & b[j % DW];
        if (sgn && ((i == DW-1) != (j == DW-1))) pp = ~pp;
        row[i+j] = pp;
      end
    end else if (sgn) begin
      row[DW]   = 1'b1;
      row[PW-1] = 1'b1;
    end
    return row;
  endfunction

  function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                          input logic [PW-1:0] z);
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {s, c};
  endfunction

  logic [CW-1:0]    r_cnt;
  logic             r_mode;
  logic [NST-1:0]   r_vld, r_first, r_last, r_sgn;
  logic [DW-1:0]    r_a [NST];
  logic [DW-1:0]    r_b [NST];
  logic [PW-1:0]    r_s [NST];
  logic [PW-1:0]    r_c [NST];
  logic [ACC_W-1:0] r_acc;

  logic [DW-1:0]    w_a [NST];
  logic [DW-1:0]    w_b [NST];
  logic [PW-1:0]    w_s [NST];
  logic [PW-1:0]    w_c [NST];
  logic [NST-1:0]   w_sgn;
  logic             w_en, w_take, w_first, w_last;
  logic [ACC_W-1:0] w_prod, w_sum, w_res;

  assign w_en     = !(out_valid && !out_ready);
  assign in_ready = w_en;
  assign w_take   = in_valid && w_en;
  assign w_first  = (r_cnt == '0);
  assign w_last   = (r_cnt == CW'(TAPS - 1));

  // Stage 0 only captures operands; stages 1..PIPE-1 (or stage 1 when PIPE=1) compress rows,
  // stage PIPE resolves the final sum/carry pair.
  always_comb begin
    w_sgn    = '0;
    w_a[0]   = in_a;
    w_b[0]   = in_b;
    w_sgn[0] = w_first ? in_signed : r_mode;
    w_s[0]   = '0;
    w_c[0]   = '0;
    for (int p = 1; p < NST; p++) begin
      w_a[p]   = r_a[p-1];
      w_b[p]   = r_b[p-1];
      w_sgn[p] = r_sgn[p-1];
      w_s[p]   = r_s[p-1];
      w_c[p]   = r_c[p-1];
      for (int j = 0; j < NR; j++) begin
        if ((p - 1) < NSL && j >= ((p - 1) * NR) / NSL && j < (p * NR) / NSL)
          {w_s[p], w_c[p]} = csa(w_s[p], w_c[p], bw_row(r_a[p-1], r_b[p-1], r_sgn[p-1], j));
      end
      if (p == PIPE) begin
        w_s[p] = w_s[p] + w_c[p];
        w_c[p] = '0;
      end
    end
  end

  assign w_prod = r_sgn[PIPE] ? ACC_W'($signed(r_s[PIPE])) : ACC_W'(r_s[PIPE]);
  assign w_sum  = (r_first[PIPE] ? '0 : r_acc) + w_prod;

`ifdef GAUSS_ROUND_EN
  localparam int RND = (2**SHIFT) / 2;
  logic [ACC_W:0] w_rnd;
  assign w_rnd = {r_sgn[PIPE] & w_sum[ACC_W-1], w_sum} + (ACC_W+1)'(RND);
  assign w_res = r_sgn[PIPE] ? ACC_W'($signed(w_rnd) >>> SHIFT) : ACC_W'(w_rnd >> SHIFT);
`else
  logic [31:0] w_unused_shift;
  assign w_unused_shift = SHIFT;
  assign w_res          = w_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_vld     <= '0;
      r_first   <= '0;
      r_last    <= '0;
      r_sgn     <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int p = 0; p < NST; p++) begin
        r_a[p] <= '0;
        r_b[p] <= '0;
        r_s[p] <= '0;
        r_c[p] <= '0;
      end
    end else if (soft_clr) begin
      r_cnt     <= '0;
      r_vld     <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
    end else if (w_en) begin
      r_vld   <= {r_vld[NST-2:0], w_take};
      r_first <= {r_first[NST-2:0], w_first};
      r_last  <= {r_last[NST-2:0], w_last};
      r_sgn   <= w_sgn;
      for (int p = 0; p < NST; p++) begin
        r_a[p] <= w_a[p];
        r_b[p] <= w_b[p];
        r_s[p] <= w_s[p];
        r_c[p] <= w_c[p];
      end
      if (w_take) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_first) r_mode <= in_signed;
      end
      if (r_vld[PIPE]) begin
        if (r_last[PIPE]) begin
          out_data <= w_res;
          r_acc    <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
      out_valid <= r_vld[PIPE] && r_last[PIPE];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dadda_mac_pipe.sv
// tb_dadda_mac_pipe: directed checks of dadda_mac_pipe (default, PIPE=1, PIPE=3 and TAPS=1 builds).
`default_nettype none

module tb_dadda_mac_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, soft_clr, in_valid, in_signed, out_ready, alt_en;
  logic [7:0]  in_a, in_b;
  logic        in_ready, out_valid;
  logic [19:0] out_data;
  logic        av;
  logic        rdy1, ov1, rdy3, ov3;
  logic [19:0] od1, od3;
  logic        t_valid, t_signed, t_rdy, t_ov;
  logic [7:0]  t_a, t_b;
  logic [15:0] t_od;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int last_acc;
  int t9;
  logic [19:0] qd[$], q1[$], q3[$];
  logic [15:0] qt[$];
  int          cd[$], c1[$], c3[$], ct[$];
  logic [7:0]  wts [9] = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd2, 8'd1};

  assign av = in_valid & alt_en;

  dadda_mac_pipe dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data));

  dadda_mac_pipe #(.PIPE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(av), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(ov1),
    .out_ready(1'b1), .out_data(od1));

  dadda_mac_pipe #(.PIPE(3)) u_p3 (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(av), .in_ready(rdy3),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(ov3),
    .out_ready(1'b1), .out_data(od3));

  dadda_mac_pipe #(.TAPS(1)) u_t1 (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(t_valid), .in_ready(t_rdy),
    .in_a(t_a), .in_b(t_b), .in_signed(t_signed), .out_valid(t_ov),
    .out_ready(1'b1), .out_data(t_od));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin qd.push_back(out_data); cd.push_back(cyc); end
    if (ov1)  begin q1.push_back(od1);  c1.push_back(cyc); end
    if (ov3)  begin q3.push_back(od3);  c3.push_back(cyc); end
    if (t_ov) begin qt.push_back(t_od); ct.push_back(cyc); end
  end

  function automatic logic [31:0] expv(input longint v, input int w);
    longint r;
    r = v;
`ifdef GAUSS_ROUND_EN
    r = (v + 64'sd8) >>> 4;
`endif
    return 32'(r & ((64'sd1 <<< w) - 64'sd1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n;
    n = 0;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) chk("accept_timeout", 32'(in_ready), 1);
    last_acc = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q;
    qd.delete(); cd.delete(); q1.delete(); c1.delete(); q3.delete(); c3.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; soft_clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    out_ready = 1'b1; alt_en = 1'b0; t_valid = 1'b0; t_a = '0; t_b = '0; t_signed = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Gaussian weights on a flat 255 patch, all three pipeline depths in parallel
    alt_en = 1'b1;
    for (int i = 0; i < 9; i++) send(8'd255, wts[i], 1'b0);
    t9 = last_acc;
    idle(8);
    chk("s1_count", qd.size(), 1);
    chk("s1_data", 32'(qd[0]), expv(4080, 20));
    chk("s1_latency", cd[0] - t9, 3);
    chk("s1_p1_data", 32'(q1[0]), expv(4080, 20));
    chk("s1_p1_latency", c1[0] - t9, 2);
    chk("s1_p3_data", 32'(q3[0]), expv(4080, 20));
    chk("s1_p3_latency", c3[0] - t9, 4);
    clear_q();

    // Extremes, three groups streamed without gaps
    for (int i = 0; i < 9; i++) send(8'd255, 8'd255, 1'b0);
    for (int i = 0; i < 9; i++) send(8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 9; i++) send(8'hFF, 8'h01, 1'b1);
    idle(8);
    chk("s2_count", qd.size(), 3);
    chk("s2_umax", 32'(qd[0]), expv(585225, 20));
    chk("s2_smin", 32'(qd[1]), expv(147456, 20));
    chk("s2_sneg", 32'(qd[2]), expv(-9, 20));
    chk("s2_gap01", cd[1] - cd[0], 9);
    chk("s2_gap12", cd[2] - cd[1], 9);
    chk("s2_p1_sneg", 32'(q1[2]), expv(-9, 20));
    chk("s2_p3_smin", 32'(q3[1]), expv(147456, 20));
    chk("s2_p3_sneg", 32'(q3[2]), expv(-9, 20));
    clear_q();

    // Backpressure while the next group streams in
    alt_en = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(8'd10, 8'd10, 1'b0);
    t9 = last_acc;
    fork
      for (int i = 0; i < 9; i++) send(8'd3, 8'd7, 1'b0);
      begin : stall
        int n;
        logic [19:0] held;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) chk("s3_valid_timeout", 32'(out_valid), 1);
        chk("s3_rise_latency", cyc - t9, 3);
        chk("s3_in_ready_low", 32'(in_ready), 0);
        held = out_data;
        chk("s3_held_value", 32'(held), expv(900, 20));
        repeat (5) begin
          @(negedge clk);
          chk("s3_hold_data", 32'(out_data), 32'(held));
          chk("s3_hold_valid", 32'(out_valid), 1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    idle(10);
    chk("s3_count", qd.size(), 2);
    chk("s3_first", 32'(qd[0]), expv(900, 20));
    chk("s3_second", 32'(qd[1]), expv(189, 20));
    clear_q();

    // Flush mid-group; a tap offered with the flush must be dropped
    for (int i = 0; i < 4; i++) send(8'd5, 8'd5, 1'b0);
    soft_clr = 1'b1; in_valid = 1'b1; in_a = 8'd50; in_b = 8'd50;
    @(posedge clk); #1 soft_clr = 1'b0; in_valid = 1'b0;
    idle(6);
    chk("s4_no_result", qd.size(), 0);
    chk("s4_out_valid", 32'(out_valid), 0);
    for (int i = 0; i < 9; i++) send(8'd1, 8'd1, 1'b0);
    send(8'hFF, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) send(8'hFF, 8'h01, 1'b1);
    idle(8);
    chk("s4_count", qd.size(), 2);
    chk("s4_ones", 32'(qd[0]), expv(9, 20));
    chk("s4_mode_latched", 32'(qd[1]), expv(2295, 20));
    clear_q();

    // Asynchronous reset with taps in flight
    send(8'd9, 8'd9, 1'b0);
    send(8'd9, 8'd9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_valid", 32'(out_valid), 0);
    chk("s5_async_data", 32'(out_data), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) send(8'd2, 8'd3, 1'b0);
    t9 = last_acc;
    idle(8);
    chk("s5_count", qd.size(), 1);
    chk("s5_data", 32'(qd[0]), expv(54, 20));
    chk("s5_latency", cd[0] - t9, 3);

    // Single-tap build acts as a pipelined multiplier
    t_a = 8'd200; t_b = 8'd100; t_signed = 1'b0; t_valid = 1'b1;
    @(negedge clk);
    chk("s6_t_ready", 32'(t_rdy), 1);
    t9 = cyc + 1;
    @(posedge clk); #1 t_a = 8'hFE; t_b = 8'd5; t_signed = 1'b1;
    @(posedge clk); #1 t_valid = 1'b0;
    idle(6);
    chk("s6_count", qt.size(), 2);
    chk("s6_umul", 32'(qt[0]), expv(20000, 16));
    chk("s6_latency", ct[0] - t9, 3);
    chk("s6_smul", 32'(qt[1]), expv(-10, 16));
    chk("s6_gap", ct[1] - ct[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
